// File: rtl/uart_rx_ctrl.sv
// Buffers completed UART receive frames in a show-ahead FIFO and throttles the receiver with watermark hysteresis.
// Optional idle timeout strobe is built when UART_RX_CTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
  parameter int DEPTH       = 8,
  parameter int HI_WM       = 6,
  parameter int LO_WM       = 2,
  parameter int DROP_ERR    = 1,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                       UART_clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       flush,
  input  logic                       rx_done_tick,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_be,
  input  logic                       rx_oe,
  input  logic                       rx_pe,
  input  logic                       rx_fe,
  output logic                       rx_stop,
  output logic                       m_valid,
  output logic [7:0]                 m_data,
  output logic [3:0]                 m_flags,
  input  logic                       m_ready,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       ovf,
  input  logic                       clr_stat,
  output logic [7:0]                 cnt_pe,
  output logic [7:0]                 cnt_fe,
  output logic [7:0]                 cnt_oe,
  output logic [7:0]                 cnt_drop,
  output logic                       timeout_pulse
);
  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {DISABLED, RUN, THROTTLE} state_t;

  state_t          state_q, state_d;
  logic            rx_stop_q, rx_stop_d;
  logic [LW-1:0]   level_q, level_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      cnt_pe_q, cnt_pe_d, cnt_fe_q, cnt_fe_d;
  logic [7:0]      cnt_oe_q, cnt_oe_d, cnt_drop_q, cnt_drop_d;
  logic [11:0]     mem_q [DEPTH];

  logic accept, err_drop, want_push, do_push, pop, full, ovf_evt;

  function automatic logic [7:0] sat_inc(input logic [7:0] c, input logic inc);
    return (inc && c != 8'hFF) ? c + 8'd1 : c;
  endfunction

  always_comb begin
    accept    = (state_q != DISABLED) && rx_done_tick;
    err_drop  = accept && (DROP_ERR != 0) && (rx_pe || rx_fe);
    want_push = accept && !err_drop;
    full      = (level_q == LW'(DEPTH));
    pop       = (level_q != '0) && m_ready;
    // Full FIFO still accepts a push when the head leaves in the same cycle.
    do_push   = want_push && !flush && (!full || pop);
    ovf_evt   = want_push && !flush && full && !pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push && !pop)      level_d = level_q + LW'(1);
      else if (!do_push && pop) level_d = level_q - LW'(1);
    end

    state_d = state_q;
    case (state_q)
      DISABLED: if (en) state_d = RUN;
      RUN:      if (!en) state_d = DISABLED;
                else if (level_d >= LW'(HI_WM)) state_d = THROTTLE;
      THROTTLE: if (!en) state_d = DISABLED;
                else if (level_d <= LW'(LO_WM)) state_d = RUN;
      default:  state_d = DISABLED;
    endcase
    rx_stop_d = (state_d != RUN);

    if (clr_stat) begin
      ovf_d      = 1'b0;
      cnt_pe_d   = '0;
      cnt_fe_d   = '0;
      cnt_oe_d   = '0;
      cnt_drop_d = '0;
    end else begin
      ovf_d      = ovf_q || ovf_evt;
      cnt_pe_d   = sat_inc(cnt_pe_q, accept && rx_pe);
      cnt_fe_d   = sat_inc(cnt_fe_q, accept && rx_fe);
      cnt_oe_d   = sat_inc(cnt_oe_q, accept && rx_oe);
      cnt_drop_d = sat_inc(cnt_drop_q, err_drop || ovf_evt);
    end
  end

  always_ff @(posedge UART_clk) begin
    if (rst) begin
      state_q    <= DISABLED;
      rx_stop_q  <= 1'b1;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ovf_q      <= 1'b0;
      cnt_pe_q   <= '0;
      cnt_fe_q   <= '0;
      cnt_oe_q   <= '0;
      cnt_drop_q <= '0;
    end else begin
      state_q    <= state_d;
      rx_stop_q  <= rx_stop_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ovf_q      <= ovf_d;
      cnt_pe_q   <= cnt_pe_d;
      cnt_fe_q   <= cnt_fe_d;
      cnt_oe_q   <= cnt_oe_d;
      cnt_drop_q <= cnt_drop_d;
    end
  end

  // Storage needs no reset: the head is masked whenever level is zero.
  always_ff @(posedge UART_clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q] <= {rx_fe, rx_pe, rx_oe, rx_be, rx_data};
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          tmo_q, tmo_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    tmo_d     = 1'b0;
    if (do_push || flush || level_d == '0) begin
      tmo_cnt_d = '0;
    end else if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
      tmo_cnt_d = '0;
      tmo_d     = 1'b1;
    end else begin
      tmo_cnt_d = tmo_cnt_q + TW'(1);
    end
  end

  always_ff @(posedge UART_clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign timeout_pulse = tmo_q;
`else
  assign timeout_pulse = 1'b0;
`endif

  assign rx_stop  = rx_stop_q;
  assign level    = level_q;
  assign m_valid  = (level_q != '0);
  assign m_data   = m_valid ? mem_q[rd_ptr_q][7:0]  : 8'h00;
  assign m_flags  = m_valid ? mem_q[rd_ptr_q][11:8] : 4'h0;
  assign ovf      = ovf_q;
  assign cnt_pe   = cnt_pe_q;
  assign cnt_fe   = cnt_fe_q;
  assign cnt_oe   = cnt_oe_q;
  assign cnt_drop = cnt_drop_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: frames pushed are queued as {flags,data} and checked when popped.
module tb_uart_rx_ctrl;
  logic       UART_clk = 1'b0;
  logic       rst = 1'b1, en = 1'b0, flush = 1'b0, rx_done_tick = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_be = 1'b0, rx_oe = 1'b0, rx_pe = 1'b0, rx_fe = 1'b0;
  logic       m_ready = 1'b0, clr_stat = 1'b0;
  logic       rx_stop, m_valid, ovf, timeout_pulse;
  logic [7:0] m_data, cnt_pe, cnt_fe, cnt_oe, cnt_drop;
  logic [3:0] m_flags, level;

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] sb[$];

  always #5 UART_clk = ~UART_clk;

  uart_rx_ctrl #(.DEPTH(8), .HI_WM(6), .LO_WM(2), .DROP_ERR(1), .TIMEOUT_CYC(16)) dut (
    .UART_clk(UART_clk), .rst(rst), .en(en), .flush(flush),
    .rx_done_tick(rx_done_tick), .rx_data(rx_data),
    .rx_be(rx_be), .rx_oe(rx_oe), .rx_pe(rx_pe), .rx_fe(rx_fe),
    .rx_stop(rx_stop), .m_valid(m_valid), .m_data(m_data), .m_flags(m_flags),
    .m_ready(m_ready), .level(level), .ovf(ovf), .clr_stat(clr_stat),
    .cnt_pe(cnt_pe), .cnt_fe(cnt_fe), .cnt_oe(cnt_oe), .cnt_drop(cnt_drop),
    .timeout_pulse(timeout_pulse)
  );

  // All tasks are entered at a falling edge and return at a falling edge.
  task automatic tick(input logic [7:0] d, input logic [3:0] f);
    rx_done_tick = 1'b1; rx_data = d; {rx_fe, rx_pe, rx_oe, rx_be} = f;
    @(negedge UART_clk);
    rx_done_tick = 1'b0; rx_data = 8'h00; {rx_fe, rx_pe, rx_oe, rx_be} = 4'h0;
  endtask

  task automatic pop_one(input int exp_lvl, input logic exp_stop);
    logic [11:0] e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++; $display("FAIL pop_sb_empty: scoreboard has no entry, m_valid=%b", m_valid);
    end else begin
      e = sb.pop_front();
      if (m_valid !== 1'b1 || {m_flags, m_data} !== e) begin
        n_err++; $display("FAIL pop_data: got v=%b %h required %h", m_valid, {m_flags, m_data}, e);
      end
    end
    m_ready = 1'b1;
    @(negedge UART_clk);
    m_ready = 1'b0;
    n_vec++;
    if (level !== 4'(exp_lvl) || rx_stop !== exp_stop) begin
      n_err++; $display("FAIL pop_level: got level=%0d stop=%b required %0d %b", level, rx_stop, exp_lvl, exp_stop);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0;
    repeat (2) @(negedge UART_clk);
    n_vec++;
    if ({level, m_valid, m_data, m_flags, rx_stop, ovf, timeout_pulse} !== {4'd0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset_outputs: got lvl=%0d v=%b d=%h f=%h stop=%b ovf=%b to=%b",
                        level, m_valid, m_data, m_flags, rx_stop, ovf, timeout_pulse);
    end
    n_vec++;
    if ({cnt_pe, cnt_fe, cnt_oe, cnt_drop} !== 32'h0) begin
      n_err++; $display("FAIL reset_counters: got %h required 0", {cnt_pe, cnt_fe, cnt_oe, cnt_drop});
    end
    rst = 1'b0; en = 1'b1;
    @(negedge UART_clk);
    n_vec++;
    if (rx_stop !== 1'b0) begin
      n_err++; $display("FAIL enable_run: rx_stop=%b required 0", rx_stop);
    end
  endtask

  task automatic test_single;
    tick(8'h55, 4'h0); sb.push_back(12'h055);
    n_vec++;
    if (m_valid !== 1'b1 || m_data !== 8'h55 || level !== 4'd1 || rx_stop !== 1'b0) begin
      n_err++; $display("FAIL single_latency: got v=%b d=%h lvl=%0d stop=%b required 1 55 1 0", m_valid, m_data, level, rx_stop);
    end
    pop_one(0, 1'b0);
  endtask

  task automatic test_watermark;
    for (int i = 1; i <= 6; i++) begin
      tick(8'(i), 4'h0); sb.push_back({4'h0, 8'(i)});
      n_vec++;
      if (level !== 4'(i) || rx_stop !== (i >= 6)) begin
        n_err++; $display("FAIL wm_fill%0d: got lvl=%0d stop=%b required %0d %b", i, level, rx_stop, i, (i >= 6));
      end
    end
    for (int l = 5; l >= 0; l--) pop_one(l, l > 2);
  endtask

  task automatic test_drop_err;
    tick(8'hAA, 4'b0100);
    tick(8'hAA, 4'b1000);
    n_vec++;
    if (level !== 4'd0 || cnt_pe !== 8'd1 || cnt_fe !== 8'd1 || cnt_drop !== 8'd2 || cnt_oe !== 8'd0) begin
      n_err++; $display("FAIL drop_err: got lvl=%0d pe=%0d fe=%0d drop=%0d oe=%0d required 0 1 1 2 0",
                        level, cnt_pe, cnt_fe, cnt_drop, cnt_oe);
    end
  endtask

  task automatic test_full;
    clr_stat = 1'b1; @(negedge UART_clk); clr_stat = 1'b0;
    n_vec++;
    if ({cnt_pe, cnt_fe, cnt_drop} !== 24'h0) begin
      n_err++; $display("FAIL clr_stat: got pe=%0d fe=%0d drop=%0d required 0", cnt_pe, cnt_fe, cnt_drop);
    end
    for (int i = 0; i < 8; i++) begin
      tick(8'h10 + 8'(i), 4'h0); sb.push_back({4'h0, 8'h10 + 8'(i)});
    end
    tick(8'h77, 4'h2);
    n_vec++;
    if (ovf !== 1'b1 || cnt_drop !== 8'd1 || level !== 4'd8 || cnt_oe !== 8'd1) begin
      n_err++; $display("FAIL full_ovf: got ovf=%b drop=%0d lvl=%0d oe=%0d required 1 1 8 1", ovf, cnt_drop, level, cnt_oe);
    end
    n_vec++;
    if (m_data !== sb[0][7:0]) begin
      n_err++; $display("FAIL full_head: got %h required %h", m_data, sb[0][7:0]);
    end
    void'(sb.pop_front());
    m_ready = 1'b1;
    tick(8'h78, 4'h0); sb.push_back(12'h078);
    m_ready = 1'b0;
    n_vec++;
    if (level !== 4'd8 || cnt_drop !== 8'd1) begin
      n_err++; $display("FAIL full_pushpop: got lvl=%0d drop=%0d required 8 1", level, cnt_drop);
    end
    for (int l = 7; l >= 0; l--) pop_one(l, l > 2);
  endtask

  task automatic test_be_flush;
    tick(8'h00, 4'b0001); sb.push_back(12'h100);
    n_vec++;
    if (m_valid !== 1'b1 || m_flags !== 4'b0001 || m_data !== 8'h00 || level !== 4'd1) begin
      n_err++; $display("FAIL be_store: got v=%b f=%b d=%h lvl=%0d required 1 0001 00 1", m_valid, m_flags, m_data, level);
    end
    flush = 1'b1;
    tick(8'h33, 4'h0);
    flush = 1'b0;
    sb.delete();
    n_vec++;
    if (m_valid !== 1'b0 || level !== 4'd0 || m_flags !== 4'h0) begin
      n_err++; $display("FAIL flush: got v=%b lvl=%0d f=%h required 0 0 0", m_valid, level, m_flags);
    end
    en = 1'b0; @(negedge UART_clk);
    tick(8'h44, 4'b0100);
    n_vec++;
    if (rx_stop !== 1'b1 || level !== 4'd0 || cnt_pe !== 8'd0) begin
      n_err++; $display("FAIL disabled: got stop=%b lvl=%0d pe=%0d required 1 0 0", rx_stop, level, cnt_pe);
    end
    en = 1'b1; @(negedge UART_clk);
    n_vec++;
    if (rx_stop !== 1'b0) begin
      n_err++; $display("FAIL reenable: rx_stop=%b required 0", rx_stop);
    end
  endtask

  task automatic test_saturate;
    clr_stat = 1'b1;
    tick(8'h5A, 4'b0100);
    clr_stat = 1'b0;
    n_vec++;
    if (cnt_pe !== 8'd0 || cnt_drop !== 8'd0 || ovf !== 1'b0) begin
      n_err++; $display("FAIL clr_wins: got pe=%0d drop=%0d ovf=%b required 0 0 0", cnt_pe, cnt_drop, ovf);
    end
    for (int i = 0; i < 260; i++) tick(8'(i), 4'b0100);
    n_vec++;
    if (cnt_pe !== 8'd255 || cnt_drop !== 8'd255 || cnt_fe !== 8'd0 || level !== 4'd0) begin
      n_err++; $display("FAIL saturate: got pe=%0d drop=%0d fe=%0d lvl=%0d required 255 255 0 0", cnt_pe, cnt_drop, cnt_fe, level);
    end
  endtask

  task automatic test_timeout;
    logic exp;
    tick(8'h99, 4'h0); sb.push_back(12'h099);
    for (int k = 1; k <= 20; k++) begin
      @(negedge UART_clk);
`ifdef UART_RX_CTRL_TIMEOUT_EN
      exp = (k == 16);
`else
      exp = 1'b0;
`endif
      n_vec++;
      if (timeout_pulse !== exp) begin
        n_err++; $display("FAIL timeout_k%0d: got %b required %b", k, timeout_pulse, exp);
      end
    end
    pop_one(0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_watermark();
    test_drop_err();
    test_full();
    test_be_flush();
    test_saturate();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
